// File: rtl/bg_tile_fetcher_pkg.sv
// Shared PPU definitions for the background tile fetcher and its helpers.
package bg_tile_fetcher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAP0,
    MAP1,
    LO0,
    LO1,
    HI0,
    HI1,
    PUSH
  } bg_fetch_state_t;

  localparam logic [12:0] BG_MAP0_BASE     = 13'h1800;
  localparam logic [12:0] BG_MAP1_BASE     = 13'h1C00;
  localparam logic [12:0] TILE_SIGNED_BASE = 13'h1000;

endpackage

// File: rtl/bg_tile_fetcher_if.sv
// VRAM read port and BG pixel shifter write port seen by the tile fetcher.
interface bg_tile_fetcher_if;
  logic [12:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [7:0]  md;
  logic        lo_strobe;
  logic        hi_strobe;
  logic        load_pulse;
  logic        shifter_ready;

  modport master (
    output vram_addr, vram_rd, md, lo_strobe, hi_strobe, load_pulse,
    input  vram_data, shifter_ready
  );

  modport slave (
    input  vram_addr, vram_rd, md, lo_strobe, hi_strobe, load_pulse,
    output vram_data, shifter_ready
  );
endinterface

// File: rtl/bg_tile_fetcher_addr_gen.sv
// Combinational BG map and tile-data address generation (shared with the window fetcher).
module bg_tile_addr_gen
  import bg_tile_fetcher_pkg::*;
(
  input  logic        map_sel,
  input  logic        tile_sel,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic [7:0]  ly,
  input  logic [4:0]  tile_x,
  input  logic [7:0]  tile,
  input  logic        plane,
  output logic [12:0] map_addr,
  output logic [12:0] tile_addr
);

  logic [7:0]  yy;
  logic [2:0]  row;
  logic [4:0]  col;
  logic [11:0] tile_off;

  // Scrolled line/column give the map entry; signed tile numbers are offsets from the 0x1000 base.
  always_comb begin
    yy        = ly + scy;
    row       = yy[2:0];
    col       = scx[7:3] + tile_x;
    map_addr  = (map_sel ? BG_MAP1_BASE : BG_MAP0_BASE) | {3'b000, yy[7:3], col};
    tile_off  = {tile, row, plane};
    tile_addr = tile_sel ? {1'b0, tile_off} : TILE_SIGNED_BASE + {tile[7], tile_off};
  end

endmodule

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: reads map entry and both bitplanes, then hands the tile to the shifter.
module bg_tile_fetcher
  import bg_tile_fetcher_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_start,
  input  logic                line_end,
  input  logic                stall,
  input  logic                lcdc_map_sel,
  input  logic                lcdc_tile_sel,
  input  logic [7:0]          scx,
  input  logic [7:0]          scy,
  input  logic [7:0]          ly,
  bg_tile_fetcher_if.master   bus,
  output logic [4:0]          tile_x,
  output logic                busy
);

  bg_fetch_state_t state, next_state;

  logic [7:0]  tile_q;
  logic [7:0]  md_q;
  logic        rd_q;
  logic [12:0] map_addr;
  logic [12:0] tile_addr;
  logic [12:0] addr_w;
  logic        rd_w;
  logic        lo_w;
  logic        hi_w;
  logic        load_w;
  logic        tile_x_inc;
  logic        tile_x_clr;
  logic        tile_cap;
  logic [7:0]  md_w;

  bg_tile_addr_gen u_addr_gen (
    .map_sel   (lcdc_map_sel),
    .tile_sel  (lcdc_tile_sel),
    .scx       (scx),
    .scy       (scy),
    .ly        (ly),
    .tile_x    (tile_x),
    .tile      (tile_q),
    .plane     (state == HI0),
    .map_addr  (map_addr),
    .tile_addr (tile_addr)
  );

  // Address mux: map address in MAP0, plane address in LO0/HI0, zero otherwise.
  always_comb begin
    addr_w = 13'h0000;
    case (state)
      MAP0:     addr_w = map_addr;
      LO0, HI0: addr_w = tile_addr;
      default:  addr_w = 13'h0000;
    endcase
  end

  // Next state and strobes; line_end beats stall, stall beats line_start, and a capture only happens if the read really went out last cycle.
  always_comb begin
    next_state = state;
    rd_w       = 1'b0;
    lo_w       = 1'b0;
    hi_w       = 1'b0;
    load_w     = 1'b0;
    tile_x_inc = 1'b0;
    tile_x_clr = 1'b0;
    tile_cap   = 1'b0;
    if (line_end) begin
      next_state = IDLE;
    end else if (stall) begin
      next_state = state;
    end else if (line_start) begin
      next_state = MAP0;
      tile_x_clr = 1'b1;
    end else begin
      case (state)
        IDLE: next_state = IDLE;
        MAP0: begin
          rd_w       = 1'b1;
          next_state = MAP1;
        end
        MAP1: begin
          if (rd_q) begin
            tile_cap   = 1'b1;
            next_state = LO0;
          end else begin
            next_state = MAP0;
          end
        end
        LO0: begin
          rd_w       = 1'b1;
          next_state = LO1;
        end
        LO1: begin
          if (rd_q) begin
            lo_w       = 1'b1;
            next_state = HI0;
          end else begin
            next_state = LO0;
          end
        end
        HI0: begin
          rd_w       = 1'b1;
          next_state = HI1;
        end
        HI1: begin
          if (rd_q) begin
            hi_w       = 1'b1;
            next_state = PUSH;
          end else begin
            next_state = HI0;
          end
        end
        PUSH: begin
          if (bus.shifter_ready) begin
            load_w     = 1'b1;
            tile_x_inc = 1'b1;
            next_state = MAP0;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Plane byte follows VRAM during a strobe and otherwise holds the last plane presented.
  always_comb begin
    md_w = (lo_w || hi_w) ? bus.vram_data : md_q;
  end

  assign bus.vram_addr  = addr_w;
  assign bus.vram_rd    = rd_w;
  assign bus.md         = md_w;
  assign bus.lo_strobe  = lo_w;
  assign bus.hi_strobe  = hi_w;
  assign bus.load_pulse = load_w;
  assign busy           = (state != IDLE);

  // State, tile counter, captured tile number and held plane byte; rd_q tracks whether VRAM data is fresh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      tile_x <= 5'd0;
      tile_q <= 8'h00;
      md_q   <= 8'h00;
      rd_q   <= 1'b0;
    end else begin
      state <= next_state;
      rd_q  <= rd_w;
      md_q  <= md_w;
      if (tile_cap) begin
        tile_q <= bus.vram_data;
      end
      if (tile_x_clr) begin
        tile_x <= 5'd0;
      end else if (tile_x_inc) begin
        tile_x <= tile_x + 5'd1;
      end
    end
  end

endmodule
